// File: rtl/btn_event_encoder.sv
`default_nettype none
// ============================================================================
// Module      : btn_event_encoder
// Description : Synchronises and debounces four push-buttons and emits one
//               valid/ready event per completed press/release gesture.
//               Define BTN_EVENT_OVERFLOW_EN to enable the sticky drop flag.
// Revision    : 1.0
// ============================================================================
module btn_event_encoder #(
  parameter int DEBOUNCE_CYCLES = 25000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [1:0] ev_code,
  output logic [3:0] ev_weight,
  output logic       ev_clear,
  output logic       ev_overflow
);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [0:0]       c_idle    = 1'b0;
  localparam logic [0:0]       c_active  = 1'b1;
  localparam logic [3:0]       c_chord   = 4'b1001;

  logic [3:0] r_sync1;
  logic [3:0] r_sync2;
  logic [3:0] w_deb;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_sync1 <= 4'b0;
      r_sync2 <= 4'b0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_deb
    logic [CNT_W-1:0] r_cnt;
    logic             r_deb;

    always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
        r_deb <= 1'b0;
      end else if (r_sync2[gi] == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_max) begin
        r_cnt <= '0;
        r_deb <= ~r_deb;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end

    assign w_deb[gi] = r_deb;
  end

  logic [0:0] r_state;
  logic [0:0] w_state_next;
  logic [3:0] r_mask;
  logic [3:0] w_mask_next;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state <= c_idle;
      r_mask  <= 4'b0;
    end else begin
      r_state <= w_state_next;
      r_mask  <= w_mask_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_mask_next  = r_mask;
    case (r_state)
      c_idle: begin
        w_mask_next = w_deb;
        if (w_deb != 4'b0) w_state_next = c_active;
      end
      c_active: begin
        if (w_deb == 4'b0) begin
          w_state_next = c_idle;
          w_mask_next  = 4'b0;
        end else begin
          w_mask_next = r_mask | w_deb;
        end
      end
      default: begin
        w_state_next = c_idle;
        w_mask_next  = 4'b0;
      end
    endcase
  end

  // Gesture classification happens on the cycle the last button is seen released.
  logic       w_ev_new;
  logic [1:0] w_ev_code;
  logic [3:0] w_ev_weight;
  logic       w_ev_clear;

  always_comb begin
    w_ev_new    = 1'b0;
    w_ev_code   = 2'd0;
    w_ev_weight = 4'b0;
    w_ev_clear  = 1'b0;
    if (r_state == c_active && w_deb == 4'b0) begin
      case (r_mask)
        4'b0001: begin w_ev_new = 1'b1; w_ev_code = 2'd0; w_ev_weight = r_mask; end
        4'b0010: begin w_ev_new = 1'b1; w_ev_code = 2'd1; w_ev_weight = r_mask; end
        4'b0100: begin w_ev_new = 1'b1; w_ev_code = 2'd2; w_ev_weight = r_mask; end
        4'b1000: begin w_ev_new = 1'b1; w_ev_code = 2'd3; w_ev_weight = r_mask; end
        c_chord: begin w_ev_new = 1'b1; w_ev_clear = 1'b1; end
        default: ;
      endcase
    end
  end

  logic r_ev_valid;
  logic w_xfer;
  logic w_load;

  assign w_xfer = r_ev_valid && ev_ready;
  assign w_load = w_ev_new && (!r_ev_valid || ev_ready);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_ev_valid <= 1'b0;
      ev_code    <= 2'd0;
      ev_weight  <= 4'b0;
      ev_clear   <= 1'b0;
    end else if (w_load) begin
      r_ev_valid <= 1'b1;
      ev_code    <= w_ev_code;
      ev_weight  <= w_ev_weight;
      ev_clear   <= w_ev_clear;
    end else if (w_xfer) begin
      r_ev_valid <= 1'b0;
    end
  end

  assign ev_valid = r_ev_valid;

`ifdef BTN_EVENT_OVERFLOW_EN
  logic r_ev_overflow;
  logic w_drop;

  assign w_drop = w_ev_new && r_ev_valid && !ev_ready;

  always_ff @(posedge clock or posedge rst) begin
    if (rst)         r_ev_overflow <= 1'b0;
    else if (w_drop) r_ev_overflow <= 1'b1;
  end

  assign ev_overflow = r_ev_overflow;
`else
  assign ev_overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btn_event_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_event_encoder
// Description : Self-checking bench for btn_event_encoder with a gesture-level
//               reference model and randomized button activity.
// Revision    : 1.0
// ============================================================================
module tb_btn_event_encoder;

  localparam int D = 4;

`ifdef BTN_EVENT_OVERFLOW_EN
  localparam logic c_ovf_on = 1'b1;
`else
  localparam logic c_ovf_on = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0;
  logic       ev_valid;
  logic       ev_ready = 1'b1;
  logic [1:0] ev_code;
  logic [3:0] ev_weight;
  logic       ev_clear;
  logic       ev_overflow;

  btn_event_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W($clog2(D + 1))) dut (
    .clock       (clock),
    .rst         (rst),
    .btn         (btn),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_code     (ev_code),
    .ev_weight   (ev_weight),
    .ev_clear    (ev_clear),
    .ev_overflow (ev_overflow)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [1:0] code;
    logic [3:0] weight;
    logic       clr;
  } ev_t;

  ev_t seen[$];
  int  n_chk = 0;
  int  n_pass = 0;

  // Every accepted handshake, stamped with the edge count at which valid was visible.
  always @(negedge clock)
    if (!rst && ev_valid && ev_ready)
      seen.push_back('{cyc, ev_code, ev_weight, ev_clear});

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; btn = 4'b0; ev_ready = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
    seen.delete();
  endtask

  // Gesture-level expectation: one button -> its index/weight, chord 0+3 -> clear, else none.
  function automatic bit model(input logic [3:0] s, output logic [6:0] f);
    f = 7'b0;
    if ($countones(s) == 1) begin
      for (int i = 0; i < 4; i++) if (s[i]) f = {2'(i), s, 1'b0};
      return 1'b1;
    end
    if (s == 4'b1001) begin
      f = 7'b0000001;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic run_gesture(input logic [3:0] s, input int hold, input bit glitch, output int rel);
    logic [3:0] left;
    int b;
    rel  = cyc;
    left = s;
    while (left != 4'b0) begin
      b = $urandom_range(0, 3);
      if (left[b]) begin
        btn[b] = 1'b1; left[b] = 1'b0;
        tick($urandom_range(0, 3));
      end
    end
    tick(D + 1);
    if (glitch) begin
      b = $urandom_range(0, 3);
      btn[b] = ~btn[b];
      tick($urandom_range(1, D - 1));
      btn[b] = ~btn[b];
    end
    tick(hold);
    left = s;
    while (left != 4'b0) begin
      b = $urandom_range(0, 3);
      if (left[b]) begin
        btn[b] = 1'b0; left[b] = 1'b0; rel = cyc;
        if (left != 4'b0) tick($urandom_range(0, 3));
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    n_chk++;
    if ({ev_valid, ev_code, ev_weight, ev_clear, ev_overflow} !== 9'b0)
      $display("FAIL reset_outputs: got %b expected 0", {ev_valid, ev_code, ev_weight, ev_clear, ev_overflow});
    else n_pass++;
    do_reset();
  endtask

  task automatic test_single_press();
    int rel;
    do_reset();
    btn = 4'b0010;
    tick(10);
    btn = 4'b0000; rel = cyc;
    tick(3 + D + 8);
    n_chk++;
    if (seen.size() !== 1) $display("FAIL single_count: got %0d expected 1", seen.size());
    else n_pass++;
    if (seen.size() == 1) begin
      n_chk++;
      if (seen[0].c !== rel + 3 + D) $display("FAIL single_latency: got %0d expected %0d", seen[0].c, rel + 3 + D);
      else n_pass++;
      n_chk++;
      if ({seen[0].code, seen[0].weight, seen[0].clr} !== {2'd1, 4'b0010, 1'b0})
        $display("FAIL single_fields: got %b expected %b", {seen[0].code, seen[0].weight, seen[0].clr}, {2'd1, 4'b0010, 1'b0});
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      btn[0] = ~btn[0];
      tick(2);
    end
    btn = 4'b0;
    tick(3 + D + 10);
    n_chk++;
    if (seen.size() !== 0 || ev_valid !== 1'b0)
      $display("FAIL bounce_no_event: got %0d events valid=%b expected 0 events", seen.size(), ev_valid);
    else n_pass++;
  endtask

  task automatic test_chord();
    int rel;
    do_reset();
    btn[0] = 1'b1; tick(6);
    btn[3] = 1'b1; tick(6);
    btn[0] = 1'b0; tick(6);
    btn[3] = 1'b0; rel = cyc;
    tick(3 + D + 8);
    n_chk++;
    if (seen.size() !== 1) $display("FAIL chord_count: got %0d expected 1", seen.size());
    else n_pass++;
    if (seen.size() == 1) begin
      n_chk++;
      if ({seen[0].c, seen[0].code, seen[0].weight, seen[0].clr} !== {rel + 3 + D, 2'd0, 4'b0, 1'b1})
        $display("FAIL chord_event: got cyc=%0d code=%0d w=%b clr=%b expected cyc=%0d clr=1",
                 seen[0].c, seen[0].code, seen[0].weight, seen[0].clr, rel + 3 + D);
      else n_pass++;
    end
    seen.delete();
    btn = 4'b0110;
    tick(10);
    btn = 4'b0;
    tick(3 + D + 8);
    n_chk++;
    if (seen.size() !== 0) $display("FAIL pair_discard: got %0d events expected 0", seen.size());
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int rel;
    do_reset();
    ev_ready = 1'b0;
    run_gesture(4'b0100, 4, 1'b0, rel);
    tick(3 + D + 5);
    n_chk++;
    if ({ev_valid, ev_code, ev_weight, ev_clear, ev_overflow} !== {1'b1, 2'd2, 4'b0100, 1'b0, 1'b0})
      $display("FAIL bp_held: got %b expected %b", {ev_valid, ev_code, ev_weight, ev_clear, ev_overflow},
               {1'b1, 2'd2, 4'b0100, 1'b0, 1'b0});
    else n_pass++;
    run_gesture(4'b1000, 4, 1'b0, rel);
    tick(3 + D + 5);
    n_chk++;
    if ({ev_valid, ev_code, ev_weight} !== {1'b1, 2'd2, 4'b0100})
      $display("FAIL bp_drop_keeps: got %b expected %b", {ev_valid, ev_code, ev_weight}, {1'b1, 2'd2, 4'b0100});
    else n_pass++;
    n_chk++;
    if (ev_overflow !== c_ovf_on) $display("FAIL bp_overflow: got %b expected %b", ev_overflow, c_ovf_on);
    else n_pass++;
    ev_ready = 1'b1;
    tick(1);
    n_chk++;
    if (ev_valid !== 1'b0) $display("FAIL bp_valid_fall: got %b expected 0", ev_valid);
    else n_pass++;
    tick(5);
    n_chk++;
    if (seen.size() !== 1 || (seen.size() == 1 && seen[0].code !== 2'd2))
      $display("FAIL bp_one_transfer: got %0d transfers expected 1 with code 2", seen.size());
    else n_pass++;
    n_chk++;
    if (ev_overflow !== c_ovf_on) $display("FAIL bp_overflow_sticky: got %b expected %b", ev_overflow, c_ovf_on);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int rel;
    do_reset();
    ev_ready = 1'b0;
    run_gesture(4'b0100, 4, 1'b0, rel);
    tick(3 + D + 5);
    btn = 4'b0010;
    tick(10);
    btn = 4'b0; rel = cyc;
    tick(2 + D);
    ev_ready = 1'b1;
    tick(1);
    n_chk++;
    if ({ev_valid, ev_code, ev_weight, ev_overflow} !== {1'b1, 2'd1, 4'b0010, 1'b0})
      $display("FAIL b2b_reload: got %b expected %b", {ev_valid, ev_code, ev_weight, ev_overflow},
               {1'b1, 2'd1, 4'b0010, 1'b0});
    else n_pass++;
    tick(1);
    n_chk++;
    if (ev_valid !== 1'b0) $display("FAIL b2b_drain: got %b expected 0", ev_valid);
    else n_pass++;
    n_chk++;
    if (seen.size() !== 2 || (seen.size() == 2 && (seen[1].c !== rel + 3 + D || seen[0].c !== rel + 2 + D)))
      $display("FAIL b2b_timing: got %0d transfers expected 2 at %0d,%0d", seen.size(), rel + 2 + D, rel + 3 + D);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int rel;
    do_reset();
    ev_ready = 1'b0;
    run_gesture(4'b0001, 4, 1'b0, rel);
    tick(3 + D + 5);
    btn = 4'b0010;
    tick(10);
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({ev_valid, ev_code, ev_weight, ev_clear, ev_overflow} !== 9'b0)
      $display("FAIL rst_async_clear: got %b expected 0", {ev_valid, ev_code, ev_weight, ev_clear, ev_overflow});
    else n_pass++;
    tick(3);
    rst = 1'b0;
    seen.delete();
    ev_ready = 1'b1;
    tick(10);
    btn = 4'b0; rel = cyc;
    tick(3 + D + 8);
    n_chk++;
    if (seen.size() !== 1) $display("FAIL rst_refresh_count: got %0d expected 1", seen.size());
    else n_pass++;
    if (seen.size() == 1) begin
      n_chk++;
      if ({seen[0].c, seen[0].code, seen[0].weight} !== {rel + 3 + D, 2'd1, 4'b0010})
        $display("FAIL rst_refresh_event: got cyc=%0d code=%0d expected cyc=%0d code=1", seen[0].c, seen[0].code, rel + 3 + D);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int         rel;
    int         r;
    logic [3:0] s;
    logic [6:0] f;
    bit         has;
    do_reset();
    for (int g = 0; g < 16; g++) begin
      r = $urandom_range(0, 3);
      if (r < 2)       s = 4'b0001 << $urandom_range(0, 3);
      else if (r == 2) s = 4'b1001;
      else             s = 4'($urandom_range(1, 15));
      seen.delete();
      run_gesture(s, $urandom_range(D + 1, D + 6), 1'($urandom_range(0, 1)), rel);
      tick(3 + D + 10);
      has = model(s, f);
      n_chk++;
      if (seen.size() !== (has ? 1 : 0))
        $display("FAIL rand_count[%0d]: mask=%b got %0d expected %0d", g, s, seen.size(), has ? 1 : 0);
      else n_pass++;
      if (has && seen.size() == 1) begin
        n_chk++;
        if (seen[0].c !== rel + 3 + D || {seen[0].code, seen[0].weight, seen[0].clr} !== f)
          $display("FAIL rand_event[%0d]: mask=%b got cyc=%0d f=%b expected cyc=%0d f=%b", g, s, seen[0].c,
                   {seen[0].code, seen[0].weight, seen[0].clr}, rel + 3 + D, f);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_chord();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
